bit_rate_alarm: RTL

BIT_RATE_ALARM -- requirements
Module: bit_rate_alarm

---
 rtl/bit_rate_pkg.sv | 36 +++
 rtl/rate_class_debounce.sv | 73 +++++++
 rtl/bit_rate_alarm.sv | 103 ++++++++++
 3 files changed

// File: rtl/bit_rate_pkg.sv
// Shared types for the bit rate alarm: default result width, alarm FSM
// states and the per-sample rate classification.
package bit_rate_pkg;

  localparam int RES_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IN_RANGE = 2'd1,
    ST_LOW      = 2'd2,
    ST_HIGH     = 2'd3
  } alarm_state_t;

  typedef enum logic [1:0] {
    CLS_IN    = 2'd0,
    CLS_BELOW = 2'd1,
    CLS_ABOVE = 2'd2
  } rate_class_t;

  function automatic alarm_state_t class_to_state(input rate_class_t c);
    case (c)
      CLS_BELOW: return ST_LOW;
      CLS_ABOVE: return ST_HIGH;
      default:   return ST_IN_RANGE;
    endcase
  endfunction

  function automatic rate_class_t state_to_class(input alarm_state_t s);
    case (s)
      ST_LOW:  return CLS_BELOW;
      ST_HIGH: return CLS_ABOVE;
      default: return CLS_IN;
    endcase
  endfunction

endpackage

// File: rtl/rate_class_debounce.sv
// Classifies each accepted rate sample against the thresholds and debounces
// class changes; change_o is a combinational strobe for the owning FSM.
module rate_class_debounce
  import bit_rate_pkg::rate_class_t, bit_rate_pkg::CLS_IN,
         bit_rate_pkg::CLS_BELOW, bit_rate_pkg::CLS_ABOVE;
#(
  parameter int RES_WIDTH   = 32,
  parameter int DEBOUNCE_NR = 3
) (
  input  logic                 clk_i,
  input  logic                 a_rst_n_i,
  input  logic                 clear_i,
  input  logic                 valid_i,
  input  logic [RES_WIDTH-1:0] rate_i,
  input  logic [RES_WIDTH-1:0] low_thr_i,
  input  logic [RES_WIDTH-1:0] high_thr_i,
  input  rate_class_t          cur_class_i,
  input  logic                 idle_i,
  output rate_class_t          new_class_o,
  output logic                 change_o,
  output logic [3:0]           dbg_cnt_o
);

  logic [3:0]  cnt_q, cnt_d, run_len;
  rate_class_t pend_q, pend_d, sample_class;

  always_comb begin
    sample_class = CLS_IN;
    // BELOW is tested first so it wins when the thresholds are inverted.
    if (rate_i < low_thr_i)       sample_class = CLS_BELOW;
    else if (rate_i > high_thr_i) sample_class = CLS_ABOVE;
  end

  // Length of the run of identical differing samples including this one.
  assign run_len = (cnt_q != 4'd0 && sample_class == pend_q) ? cnt_q + 4'd1 : 4'd1;

  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    change_o = 1'b0;
    if (clear_i) begin
      cnt_d  = 4'd0;
      pend_d = CLS_IN;
    end else if (valid_i) begin
      if (idle_i) begin
        change_o = 1'b1;
        cnt_d    = 4'd0;
      end else if (sample_class == cur_class_i) begin
        cnt_d = 4'd0;
      end else if (run_len == 4'(DEBOUNCE_NR)) begin
        change_o = 1'b1;
        cnt_d    = 4'd0;
      end else begin
        cnt_d  = run_len;
        pend_d = sample_class;
      end
    end
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      cnt_q  <= 4'd0;
      pend_q <= CLS_IN;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign new_class_o = sample_class;
  assign dbg_cnt_o   = cnt_q;

endmodule

// File: rtl/bit_rate_alarm.sv
// Bit rate alarm: debounced LOW/IN_RANGE/HIGH state machine with alarm
// pulse, saturating alarm counter and min/max rate statistics.
module bit_rate_alarm
  import bit_rate_pkg::alarm_state_t, bit_rate_pkg::rate_class_t,
         bit_rate_pkg::ST_IDLE, bit_rate_pkg::ST_LOW, bit_rate_pkg::ST_HIGH,
         bit_rate_pkg::class_to_state, bit_rate_pkg::state_to_class;
#(
  parameter int RES_WIDTH   = bit_rate_pkg::RES_WIDTH,
  parameter int DEBOUNCE_NR = 3
) (
  input  logic                 clk_i,
  input  logic                 a_rst_n_i,
  input  logic [RES_WIDTH-1:0] rate_i,
  input  logic                 rate_valid_i,
  input  logic [RES_WIDTH-1:0] low_thr_i,
  input  logic [RES_WIDTH-1:0] high_thr_i,
  input  logic                 clear_i,
  output logic [1:0]           state_o,
  output logic                 low_alarm_o,
  output logic                 high_alarm_o,
  output logic                 alarm_pulse_o,
  output logic [RES_WIDTH-1:0] rate_min_o,
  output logic [RES_WIDTH-1:0] rate_max_o,
  output logic [15:0]          alarm_cnt_o
);

  alarm_state_t         state_q, state_d;
  rate_class_t          new_class;
  logic                 change, pulse_d, pulse_q, first_q;
  logic                 low_q, high_q;
  logic [15:0]          alarm_cnt_q;
  logic [RES_WIDTH-1:0] min_q, max_q;
  logic [3:0]           dbg_cnt;

  rate_class_debounce #(
    .RES_WIDTH  (RES_WIDTH),
    .DEBOUNCE_NR(DEBOUNCE_NR)
  ) u_deb (
    .clk_i      (clk_i),
    .a_rst_n_i  (a_rst_n_i),
    .clear_i    (clear_i),
    .valid_i    (rate_valid_i),
    .rate_i     (rate_i),
    .low_thr_i  (low_thr_i),
    .high_thr_i (high_thr_i),
    .cur_class_i(state_to_class(state_q)),
    .idle_i     (state_q == ST_IDLE),
    .new_class_o(new_class),
    .change_o   (change),
    .dbg_cnt_o  (dbg_cnt)
  );

  always_comb begin
    state_d = state_q;
    pulse_d = 1'b0;
    if (clear_i) begin
      state_d = ST_IDLE;
    end else if (change) begin
      state_d = class_to_state(new_class);
      pulse_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
    end
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state_q     <= ST_IDLE;
      low_q       <= 1'b0;
      high_q      <= 1'b0;
      pulse_q     <= 1'b0;
      alarm_cnt_q <= 16'd0;
      min_q       <= '0;
      max_q       <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      low_q   <= (state_d == ST_LOW);
      high_q  <= (state_d == ST_HIGH);
      pulse_q <= pulse_d;
      if (clear_i) begin
        alarm_cnt_q <= 16'd0;
        min_q       <= '0;
        max_q       <= '0;
        first_q     <= 1'b1;
      end else begin
        if (pulse_d && alarm_cnt_q != 16'hFFFF) alarm_cnt_q <= alarm_cnt_q + 16'd1;
        if (rate_valid_i) begin
          first_q <= 1'b0;
          if (first_q || rate_i < min_q) min_q <= rate_i;
          if (first_q || rate_i > max_q) max_q <= rate_i;
        end
      end
    end
  end

  assign state_o       = state_q;
  assign low_alarm_o   = low_q;
  assign high_alarm_o  = high_q;
  assign alarm_pulse_o = pulse_q;
  assign rate_min_o    = min_q;
  assign rate_max_o    = max_q;
  assign alarm_cnt_o   = alarm_cnt_q;

endmodule
